// File: rtl/lcd_responder.sv
// lcd_responder -- behavioural model of an HD44780-style 2x16 character LCD,
// seen from the controller side of the bus.
//
// Transfers complete on the falling edge of lcd_e (registered copy high,
// live input low). Writes update a 32-byte display RAM, the address counter
// (AC), the increment/decrement mode and the display-on flag, then hold
// busy for a fixed number of clk_50 cycles. Writes arriving while busy are
// dropped and reported on err_overrun.
//
// Optional feature: define LCD_RESP_READBACK_EN to let the controller read
// {busy, AC} (rs=0) or ram[AC] (rs=1) while lcd_e is high; a data read
// steps AC. Without it, reads are ignored and the read bus stays quiet.
//
// Parameters:
//   BUSY_CYCLES  - busy length after a normal instruction or data write
//   CLEAR_CYCLES - busy length after clear/home; must be >= 32 so the
//                  clear fill always finishes inside the busy window
// Ports:
//   clk_50       - clock, rising edge
//   rst          - asynchronous active-high reset
//   lcd_d_in     - controller data bus
//   lcd_rs       - register select (0 instruction, 1 data)
//   lcd_rw       - 0 write, 1 read
//   lcd_e        - enable strobe
//   lcd_d_out    - read data toward the controller
//   lcd_d_oe     - lcd_d_out valid
//   rd_addr      - host display RAM index {line, column[3:0]}
//   rd_data      - registered display RAM byte at rd_addr
//   disp_on      - display-on flag
//   busy         - busy flag
//   cmd_strobe   - one-cycle pulse per accepted transfer
//   err_overrun  - one-cycle pulse per write dropped while busy
module lcd_responder #(
  parameter int BUSY_CYCLES  = 50,
  parameter int CLEAR_CYCLES = 2000
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic [7:0] lcd_d_in,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  output logic [7:0] lcd_d_out,
  output logic       lcd_d_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       disp_on,
  output logic       busy,
  output logic       cmd_strobe,
  output logic       err_overrun
);

  localparam int MAXC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] BUSY_LD  = CW'(BUSY_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_CYCLES - 1);
  localparam logic [7:0]    BLANK    = 8'h20;

`ifdef LCD_RESP_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  typedef enum logic {ST_IDLE, ST_FILL} fill_state_t;

  // AC walks 0x00..0x0F, 0x40..0x4F as one 32-entry ring.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) return (a[3:0] == 4'hF) ? {~a[6], 6'b000000} : a + 7'd1;
    else     return (a[3:0] == 4'h0) ? {~a[6], 2'b00, 4'hF} : a - 7'd1;
  endfunction

  logic             e_q;
  logic [6:0]       ac, ac_nxt;
  logic             inc_mode, inc_nxt;
  logic             disp_nxt;
  logic [CW-1:0]    busy_cnt;
  logic [7:0]       ram [32];
  fill_state_t      state, state_nxt;
  logic [4:0]       fill_idx;

  logic             fall, wr_acc, wr_drop, rd_acc;
  logic             start_busy, long_busy, start_fill, data_we;
  logic             ram_we;
  logic [4:0]       ram_wa;
  logic [7:0]       ram_wd;
  logic [4:0]       ac_idx;

  // e_q resets low, so a falling edge can only be seen once lcd_e has been
  // sampled high after reset.
  assign fall    = e_q & ~lcd_e;
  assign wr_acc  = fall & ~lcd_rw & ~busy;
  assign wr_drop = fall & ~lcd_rw &  busy;
  assign rd_acc  = fall &  lcd_rw & READBACK;
  assign ac_idx  = {ac[6], ac[3:0]};

  // ---------------------------------------------------------------------
  // Transfer decode
  // ---------------------------------------------------------------------
  always_comb begin
    ac_nxt     = ac;
    inc_nxt    = inc_mode;
    disp_nxt   = disp_on;
    start_busy = 1'b0;
    long_busy  = 1'b0;
    start_fill = 1'b0;
    data_we    = 1'b0;
    if (wr_acc) begin
      start_busy = 1'b1;
      if (lcd_rs) begin
        data_we = 1'b1;
        ac_nxt  = ac_step(ac, inc_mode);
      end else if (lcd_d_in == 8'h01) begin
        ac_nxt     = 7'h00;
        inc_nxt    = 1'b1;
        start_fill = 1'b1;
        long_busy  = 1'b1;
      end else if (lcd_d_in[7:1] == 7'b0000001) begin
        ac_nxt    = 7'h00;
        long_busy = 1'b1;
      end else if (lcd_d_in[7:2] == 6'b000001) begin
        inc_nxt = lcd_d_in[1];
      end else if (lcd_d_in[7:3] == 5'b00001) begin
        disp_nxt = lcd_d_in[2];
      end else if (lcd_d_in[7:3] == 5'b00010) begin
        ac_nxt = ac_step(ac, lcd_d_in[2]);
      end else if (lcd_d_in[7]) begin
        // bits 5:4 are discarded so any DDRAM address folds onto a legal one
        ac_nxt = {lcd_d_in[6], 2'b00, lcd_d_in[3:0]};
      end
    end else if (rd_acc && lcd_rs) begin
      ac_nxt = ac_step(ac, inc_mode);
    end
  end

  // ---------------------------------------------------------------------
  // Clear-fill FSM: blanks one RAM byte per cycle after a clear command.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      fill_idx <= 5'd0;
    end else begin
      state    <= state_nxt;
      fill_idx <= (state == ST_FILL) ? fill_idx + 5'd1 : 5'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_fill) state_nxt = ST_FILL;
      ST_FILL: if (fill_idx == 5'd31) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The fill owns the write port; busy keeps data writes out meanwhile.
  always_comb begin
    ram_we = 1'b0;
    ram_wa = ac_idx;
    ram_wd = lcd_d_in;
    if (state == ST_FILL) begin
      ram_we = 1'b1;
      ram_wa = fill_idx;
      ram_wd = BLANK;
    end else if (data_we) begin
      ram_we = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      e_q         <= 1'b0;
      ac          <= 7'h00;
      inc_mode    <= 1'b1;
      disp_on     <= 1'b0;
      cmd_strobe  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      e_q         <= lcd_e;
      ac          <= ac_nxt;
      inc_mode    <= inc_nxt;
      disp_on     <= disp_nxt;
      cmd_strobe  <= wr_acc | rd_acc;
      err_overrun <= wr_drop;
    end
  end

  // busy is high for exactly the loaded count + 1 cycles.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      busy_cnt <= '0;
    end else if (start_busy) begin
      busy     <= 1'b1;
      busy_cnt <= long_busy ? CLEAR_LD : BUSY_LD;
    end else if (busy) begin
      if (busy_cnt == '0) busy <= 1'b0;
      else                busy_cnt <= busy_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) ram[i] <= BLANK;
    end else if (ram_we) begin
      ram[ram_wa] <= ram_wd;
    end
  end

  // Host port: forward a same-cycle write so the newest value always wins.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst)                             rd_data <= BLANK;
    else if (ram_we && ram_wa == rd_addr) rd_data <= ram_wd;
    else                                 rd_data <= ram[rd_addr];
  end

  // ---------------------------------------------------------------------
  // Controller read bus
  // ---------------------------------------------------------------------
`ifdef LCD_RESP_READBACK_EN
  assign lcd_d_oe  = ~rst & lcd_e & lcd_rw;
  assign lcd_d_out = !lcd_d_oe ? 8'h00 : (lcd_rs ? ram[ac_idx] : {busy, ac});
`else
  assign lcd_d_oe  = 1'b0;
  assign lcd_d_out = 8'h00;
`endif

endmodule
